// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
package lexington;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_HOLDOFF = 2'd2
   } irq_state_t;

   localparam logic [31:0] MCAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
   localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

   localparam int unsigned MIP_MSIP = 3;
   localparam int unsigned MIP_MTIP = 7;
   localparam int unsigned MIP_MEIP = 11;

   function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
      return m;
   endfunction

   // Fixed priority MEI > MSI > MTI; caller guarantees at least one source is active.
   function automatic logic [31:0] pick_cause(input logic mei, input logic msi);
      if (mei)      return MCAUSE_MEI;
      else if (msi) return MCAUSE_MSI;
      else          return MCAUSE_MTI;
   endfunction

endpackage

// File: rtl/irq_ctrl_cdc_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous level inputs.
module cdc_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: MSIP/EXT_PEND/EXT_EN registers, mip view, request FSM.
// External interrupt logic is compiled in only when LEXINGTON_IRQ_EXT_EN is defined.
//
// state       | meaning
// IRQ_IDLE    | no request; latch highest-priority eligible cause
// IRQ_REQ     | irq_req high, cause held until ack or source withdrawn
// IRQ_HOLDOFF | one dead cycle after ack so software's clear can land
module irq_ctrl
   import lexington::*;
#(
   parameter int NUM_EXT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [1:0]         addr,
   input  logic [31:0]        wr_data,
   input  logic [3:0]         wr_strobe,
   output logic [31:0]        rd_data,
   input  logic               mtime_irq,
   input  logic [NUM_EXT-1:0] ext_irq,
   input  logic               mstatus_mie,
   input  logic [31:0]        mie,
   output logic [31:0]        mip,
   output logic               irq_req,
   output logic [31:0]        irq_cause,
   input  logic               irq_ack
);

   logic        msip;
   logic [31:0] ext_pend_w;
   logic [31:0] ext_en_w;
   logic [31:0] active;
   logic        eligible;
   logic        src_live;
   irq_state_t  state_q;
   logic [31:0] cause_q;

`ifdef LEXINGTON_IRQ_EXT_EN
   logic [NUM_EXT-1:0] ext_sync;
   logic [NUM_EXT-1:0] ext_prev;
   logic [NUM_EXT-1:0] ext_rise;
   logic [NUM_EXT-1:0] ext_pend;
   logic [NUM_EXT-1:0] ext_en;
   logic [NUM_EXT-1:0] pend_clr;
   logic [31:0]        byte_mask;
   logic               unused_wr;

   cdc_sync #(.WIDTH(NUM_EXT)) u_ext_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ext_irq),
      .q     (ext_sync)
   );

   assign byte_mask = strobe_mask(wr_strobe);
   assign ext_rise  = ext_sync & ~ext_prev;
   assign pend_clr  = (wr_en && addr == 2'd1) ? (wr_data[NUM_EXT-1:0] & byte_mask[NUM_EXT-1:0])
                                              : '0;
   assign unused_wr = ^{wr_data, byte_mask};

   // A fresh edge in the same cycle as a W1C keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_prev <= '0;
         ext_pend <= '0;
         ext_en   <= '0;
      end else begin
         ext_prev <= ext_sync;
         ext_pend <= (ext_pend & ~pend_clr) | ext_rise;
         if (wr_en && addr == 2'd2)
            ext_en <= (ext_en & ~byte_mask[NUM_EXT-1:0])
                    | (wr_data[NUM_EXT-1:0] & byte_mask[NUM_EXT-1:0]);
      end
   end

   always_comb begin
      ext_pend_w = '0;
      ext_en_w   = '0;
      ext_pend_w[NUM_EXT-1:0] = ext_pend;
      ext_en_w[NUM_EXT-1:0]   = ext_en;
   end
`else
   logic unused_ext;

   assign ext_pend_w = '0;
   assign ext_en_w   = '0;
   assign unused_ext = ^{ext_irq, wr_data[31:1], wr_strobe[3:1]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         msip <= 1'b0;
      else if (wr_en && addr == 2'd0 && wr_strobe[0])
         msip <= wr_data[0];
   end

   always_comb begin
      mip           = '0;
      mip[MIP_MSIP] = msip;
      mip[MIP_MTIP] = mtime_irq;
      mip[MIP_MEIP] = |(ext_pend_w & ext_en_w);
   end

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (addr)
            2'd0:    rd_data = {31'b0, msip};
            2'd1:    rd_data = ext_pend_w;
            2'd2:    rd_data = ext_en_w;
            default: rd_data = '0;
         endcase
      end
   end

   assign active   = mip & mie;
   assign eligible = mstatus_mie && (|active);
   // Cause codes equal their mip bit index, so the latched cause selects its own source.
   assign src_live = active[cause_q[4:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IRQ_IDLE;
         cause_q <= '0;
      end else begin
         case (state_q)
            IRQ_IDLE: begin
               if (eligible) begin
                  cause_q <= pick_cause(active[MIP_MEIP], active[MIP_MSIP]);
                  state_q <= IRQ_REQ;
               end
            end
            IRQ_REQ: begin
               if (irq_ack)
                  state_q <= IRQ_HOLDOFF;
               else if (!mstatus_mie || !src_live)
                  state_q <= IRQ_IDLE;
            end
            IRQ_HOLDOFF: state_q <= IRQ_IDLE;
            default:     state_q <= IRQ_IDLE;
         endcase
      end
   end

   assign irq_req   = (state_q == IRQ_REQ);
   assign irq_cause = cause_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-level interrupt controller that consumes the timer interrupt produced by `mtime`, plus a memory-mapped software-interrupt bit and a bank of asynchronous external interrupt lines. It builds the `mip` view for the CSR file, prioritises pending sources, and raises a held request with a latched cause to the core's trap unit. It sits on the DBus as a 4-word peripheral beside `mtime`.

## Interface
- `NUM_EXT`, 8, number of external interrupt lines (1..32)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `rd_en`  in  1  DBus read enable
- `wr_en`  in  1  DBus write enable
- `addr`  in  2  DBus word address: 0 MSIP, 1 EXT_PEND, 2 EXT_EN, 3 reserved
- `wr_data`  in  32  DBus write data (`rv32::word`)
- `wr_strobe`  in  4  DBus byte enables
- `rd_data`  out  32  DBus read data
- `mtime_irq`  in  1  level timer interrupt from `mtime`
- `ext_irq`  in  NUM_EXT  asynchronous external interrupt lines, rising-edge triggered
- `mstatus_mie`  in  1  global machine interrupt enable
- `mie`  in  32  `mie` CSR value
- `mip`  out  32  `mip` CSR read value
- `irq_req`  out  1  interrupt request to trap unit
- `irq_cause`  out  32  `mcause` value for the request
- `irq_ack`  in  1  trap unit accepts request

## Operation
- MSIP register: bit 0 only, byte strobe 0 writes it; other bits read 0.
- EXT_PEND: bit i set on a synchronised rising edge of `ext_irq[i]`; write-1-to-clear per strobed byte; set wins over clear in the same cycle.
- EXT_EN: plain R/W mask, bits >= NUM_EXT read 0.
- Reads combinational; `rd_data` = 0 when `!rd_en` or addr 3.
- `mip`: bit 3 = MSIP, bit 7 = `mtime_irq`, bit 11 = |(EXT_PEND & EXT_EN); all other bits 0.
- Eligible = `mstatus_mie` & (`mip` & `mie`) non-zero. Priority MEI > MSI > MTI; causes `0x8000000B`, `0x80000003`, `0x80000007`.
- FSM `IDLE`/`REQ`/`HOLDOFF`:
  - IDLE: if eligible, latch highest-priority cause -> REQ.
  - REQ: `irq_req`=1, `irq_cause` stable. `irq_ack` -> HOLDOFF. If `mstatus_mie` falls or the latched source's `mip&mie` bit drops (no ack that cycle) -> IDLE, request withdrawn. A higher-priority source arriving does not change the latched cause.
  - HOLDOFF: one cycle, `irq_req`=0, then IDLE (gives software's clear a cycle to land).
- `irq_ack` outside REQ is ignored.

## Timing
- Reset: MSIP, EXT_PEND, EXT_EN, sync flops = 0; state IDLE; `irq_req`=0, `irq_cause`=0; `mip` follows `mtime_irq` only.
- `mtime_irq`/MSIP/`mie` eligible at edge N -> `irq_req` high after edge N.
- `ext_irq` rising before edge N: sync1 at N, sync2 at N+1, EXT_PEND set at N+2 (`mip[11]` visible), `irq_req` after N+3.
- Ack at edge N -> `irq_req` low after N; earliest next request after N+2.
- Reset mid-REQ: `irq_req` drops asynchronously; pending state lost.
- MSIP/EXT_EN/EXT_PEND writes visible in `mip` the cycle after the write edge.

## Configuration
- `LEXINGTON_IRQ_EXT_EN` defined: sync chain, edge detect, EXT_PEND, EXT_EN compiled in.
- Undefined: `ext_irq` ignored, `mip[11]`=0, addr 1 and 2 read 0 and writes are dropped, MEI never requested.

## Structure
- `lexington` package: `irq_state_t` enum, cause constants `MCAUSE_MSI/MTI/MEI`, `mip` bit indices `MIP_MSIP/MTIP/MEIP`.
- Sub-module `cdc_sync`: parameterised-width 2-flop synchroniser with async active-low reset, one instance over `ext_irq`.

## Test plan
- Reset, `mtime_irq`=1, `mie`=0x80, `mstatus_mie`=1 -> `irq_req`=1 after one edge, `irq_cause`=0x80000007, `mip`=0x80; ack -> low, HOLDOFF observed.
- Write MSIP=1 with `mtime_irq`=1, `mie`=0x88 -> cause 0x80000003; write MSIP=0, ack -> next cause 0x80000007.
- EXT_EN=0x01, pulse `ext_irq[0]` -> EXT_PEND=0x01 at N+2, `irq_req` at N+3, cause 0x8000000B; W1C 0x01 -> `mip[11]`=0.
- W1C on bit 0 in the same cycle as a new synchronised edge -> EXT_PEND bit 0 remains 1.
- In REQ for MTI, drop `mtime_irq` before ack -> `irq_req` falls next cycle, state IDLE, no cause change.
- Build without `LEXINGTON_IRQ_EXT_EN`, toggle `ext_irq`=0xFF, write addr 2 with 0xFF -> `mip`=0, reads of addr 1/2 return 0.
